icap_reboot_seq: RTL and testbench

Wishbone master that drives the 8-bit ICAP slave to trigger a Spartan-3A multiboot reconfiguration.
- On a single `go` pulse it latches a 24-bit flash boot address.
- It then issues the fixed 18-byte IPROG command stream, one Wishbone write per byte, with ack handshaking and a per-transfer timeout.
- It sits between the firmware-visible control register (`go`, `boot_addr`) and the ICAP Wishbone slave, and is the only master of that slave.

---
 rtl/icap_reboot_seq.sv | 184 ++++++++++++++++++
 tb/tb_icap_reboot_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icap_reboot_seq.sv
// Wishbone master that feeds the 18-byte Spartan-3A IPROG stream into the ICAP
// slave, one write per byte with ack handshaking and a per-transfer timeout.
module icap_reboot_seq #(
  parameter bit          BITSWAP = 1'b1,
  parameter int unsigned TIMEOUT = 255,
  parameter logic [7:0]  OPCODE  = 8'h0B
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [23:0] boot_addr,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] dat_o,
  input  logic        ack_i,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DONE} state_t;

  localparam logic [4:0] LAST_IDX     = 5'd17;
  // cnt_reg holds (REQ cycles elapsed - 1), so the last allowed cycle sees TIMEOUT-1
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [4:0]  idx_reg, idx_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [23:0] addr_reg, addr_next;
  logic        req_reg, req_next;
  logic [7:0]  byte_reg, byte_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;

  logic [4:0]  load_idx;
  logic [23:0] load_addr;
  logic [7:0]  load_raw;
  logic [7:0]  load_byte;

  function automatic logic [7:0] stream_byte(input logic [4:0] k, input logic [23:0] a);
    logic [7:0] b;
    case (k)
      5'd0, 5'd1: b = 8'hFF;
      5'd2:       b = 8'hAA;
      5'd3:       b = 8'h99;
      5'd4:       b = 8'h32;
      5'd5:       b = 8'h61;
      5'd6:       b = a[15:8];
      5'd7:       b = a[7:0];
      5'd8:       b = 8'h32;
      5'd9:       b = 8'h81;
      5'd10:      b = OPCODE;
      5'd11:      b = a[23:16];
      5'd12:      b = 8'h30;
      5'd13:      b = 8'hA1;
      5'd14:      b = 8'h00;
      5'd15:      b = 8'h0E;
      5'd16:      b = 8'h20;
      default:    b = 8'h00;
    endcase
    return b;
  endfunction

  // Byte to present on the next REQ entry: byte 0 of the new address from IDLE,
  // otherwise the following byte of the latched address.
  always_comb begin
    if (state_reg == S_IDLE) begin
      load_idx  = '0;
      load_addr = boot_addr;
    end else begin
      load_idx  = idx_reg + 5'd1;
      load_addr = addr_reg;
    end
    load_raw = stream_byte(load_idx, load_addr);
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_swap
    if (BITSWAP) begin : g_rev
      assign load_byte[gi] = load_raw[7-gi];
    end else begin : g_fwd
      assign load_byte[gi] = load_raw[gi];
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    req_next   = req_reg;
    byte_next  = byte_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    err_next   = err_reg;

    case (state_reg)
      S_IDLE: begin
        req_next  = 1'b0;
        busy_next = 1'b0;
        if (go) begin
          addr_next  = boot_addr;
          idx_next   = '0;
          cnt_next   = '0;
          err_next   = 1'b0;
          req_next   = 1'b1;
          busy_next  = 1'b1;
          byte_next  = load_byte;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        // ack has priority over an expiring timeout in the same cycle
        if (ack_i) begin
          req_next = 1'b0;
          if (idx_reg == LAST_IDX) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = S_DONE;
          end else begin
            state_next = S_GAP;
          end
        end else if (cnt_reg == TIMEOUT_LAST) begin
          err_next   = 1'b1;
          req_next   = 1'b0;
          busy_next  = 1'b0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      S_GAP: begin
        idx_next   = idx_reg + 5'd1;
        cnt_next   = '0;
        req_next   = 1'b1;
        byte_next  = load_byte;
        state_next = S_REQ;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        req_next   = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      req_reg   <= 1'b0;
      byte_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      req_reg   <= req_next;
      byte_reg  <= byte_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign cyc_o = req_reg;
  assign stb_o = req_reg;
  assign we_o  = req_reg;
  assign dat_o = {24'd0, byte_reg};
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_icap_reboot_seq.sv
// Bench for icap_reboot_seq: plain-BITSWAP and bit-reversed instances share one
// stimulus; a transfer-level model is checked against both every cycle.
module tb_icap_reboot_seq;

  localparam int         TO  = 16;
  localparam logic [7:0] OPC = 8'h0B;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [23:0] boot_addr = '0;
  logic        ack = 1'b0;

  logic        c0, s0, w0, b0, dn0, e0;
  logic        c1, s1, w1, b1, dn1, e1;
  logic [31:0] d0, d1;

  int checks = 0;
  int errors = 0;

  icap_reboot_seq #(.BITSWAP(1'b0), .TIMEOUT(TO), .OPCODE(OPC)) dut0 (
    .clk(clk), .reset(reset), .go(go), .boot_addr(boot_addr),
    .cyc_o(c0), .stb_o(s0), .we_o(w0), .dat_o(d0), .ack_i(ack),
    .busy(b0), .done(dn0), .err(e0)
  );

  icap_reboot_seq #(.BITSWAP(1'b1), .TIMEOUT(TO), .OPCODE(OPC)) dut1 (
    .clk(clk), .reset(reset), .go(go), .boot_addr(boot_addr),
    .cyc_o(c1), .stb_o(s1), .we_o(w1), .dat_o(d1), .ack_i(ack),
    .busy(b1), .done(dn1), .err(e1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input logic [23:0] a, input int k);
    logic [15:0] w [9];
    w = '{16'hFFFF, 16'hAA99, 16'h3261, a[15:0], 16'h3281, {OPC, a[23:16]},
          16'h30A1, 16'h000E, 16'h2000};
    return (k % 2 == 0) ? w[k/2][15:8] : w[k/2][7:0];
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Transfer-level reference: phase 0 idle, 1 strobing, 2 gap, 3 done pulse
  int          m_ph = 0, m_pos = 0, m_cnt = 0;
  bit          m_err = 1'b0, m_valid = 1'b0;
  logic [7:0]  m_dat = '0;
  logic [23:0] m_addr = '0;

  always @(posedge clk) begin : model
    int ph, pos, cnt;
    bit er;
    logic [7:0] dv;
    logic [23:0] ad;
    ph = m_ph; pos = m_pos; cnt = m_cnt; er = m_err; dv = m_dat; ad = m_addr;
    if (reset) begin
      ph = 0; pos = 0; cnt = 0; er = 1'b0; dv = '0;
    end else begin
      case (ph)
        0: if (go) begin
          ad = boot_addr; pos = 0; cnt = 1; er = 1'b0; ph = 1; dv = mbyte(ad, 0);
        end
        1: if (ack) ph = (pos == 17) ? 3 : 2;
           else if (cnt == TO) begin er = 1'b1; ph = 0; end
           else cnt = cnt + 1;
        2: begin pos = pos + 1; cnt = 1; ph = 1; dv = mbyte(ad, pos); end
        default: ph = 0;
      endcase
    end
    m_ph <= ph; m_pos <= pos; m_cnt <= cnt; m_err <= er; m_dat <= dv; m_addr <= ad;
    if (reset) m_valid <= 1'b1;
  end

  always @(negedge clk) begin : compare
    logic rq, bz;
    if (m_valid) begin
      rq = (m_ph == 1);
      bz = (m_ph == 1) || (m_ph == 2);
      check("dut0_cycle", {26'd0, c0, s0, w0, b0, dn0, e0, d0},
            {26'd0, rq, rq, rq, bz, (m_ph == 3), m_err, 24'd0, m_dat});
      check("dut1_cycle", {26'd0, c1, s1, w1, b1, dn1, e1, d1},
            {26'd0, rq, rq, rq, bz, (m_ph == 3), m_err, 24'd0, rev8(m_dat)});
    end
  end

  // Slave model and bus monitor
  int         ack_lat = 3, scnt = 0;
  bit         rand_lat = 1'b0, spurious = 1'b0;
  logic [7:0] wq0[$], wq1[$];
  int         cyc_n = 0, first_stb = -1, done_cyc = -1, done_cnt = 0, stb_hi = 0, gap_n = 0;

  always @(negedge clk) begin : slave
    cyc_n = cyc_n + 1;
    if (s0) begin
      stb_hi = stb_hi + 1;
      if (first_stb < 0) first_stb = cyc_n;
    end else if (b0) gap_n = gap_n + 1;
    if (dn0) begin done_cnt = done_cnt + 1; done_cyc = cyc_n; end
    if (s0) begin
      scnt = scnt + 1;
      ack = (ack_lat != 0) && (scnt == ack_lat);
      if (ack) begin wq0.push_back(d0[7:0]); wq1.push_back(d1[7:0]); end
    end else begin
      scnt = 0;
      ack = spurious && ($urandom_range(0, 3) == 0);
      if (rand_lat) ack_lat = $urandom_range(1, 6);
    end
  end

  // result: 1 done, 2 timeout err, 3 reset applied, 0 budget expired
  task automatic run(input logic [23:0] a, input int kind, input int at, output int result);
    int acted;
    acted = 0;
    wq0.delete(); wq1.delete();
    done_cnt = 0; first_stb = -1; done_cyc = -1; stb_hi = 0; gap_n = 0;
    boot_addr = a;
    go = 1'b1;
    result = 0;
    for (int c = 0; c < 800 && result == 0; c++) begin
      @(negedge clk); #1;
      go = 1'b0;
      if (dn0) result = 1;
      else if (e0 && !b0) result = 2;
      if (result == 0 && acted == 0 && wq0.size() == at) begin
        if (kind == 1) begin
          go = 1'b1; boot_addr = $urandom; acted = 1;
        end else if (kind == 2) begin
          reset = 1'b1; acted = 1;
          @(negedge clk); #1;
          check("rst_cyc", {63'd0, c0}, 64'd0);
          check("rst_stb", {63'd0, s0}, 64'd0);
          check("rst_we", {63'd0, w0}, 64'd0);
          check("rst_dat", {32'd0, d0}, 64'd0);
          check("rst_busy", {63'd0, b0}, 64'd0);
          check("rst_done_err", {62'd0, dn0, e0}, 64'd0);
          reset = 1'b0;
          result = 3;
        end
      end
    end
    go = 1'b0;
    if (result == 0) check("run_budget_expired", 64'd1, 64'd0);
    repeat (3) begin @(negedge clk); #1; end
    $display("run addr=%h kind=%0d result=%0d writes=%0d dones=%0d", a, kind, result, wq0.size(), done_cnt);
  endtask

  task automatic check_stream(input string name, input logic [23:0] a);
    int bad;
    bad = 0;
    if (wq0.size() != 18 || wq1.size() != 18) bad = 100;
    else for (int i = 0; i < 18; i++)
      if (wq0[i] !== mbyte(a, i) || wq1[i] !== rev8(mbyte(a, i))) bad++;
    check(name, 64'(bad), 64'd0);
  endtask

  initial begin
    logic [7:0] lit [18];
    int res;
    lit = '{8'hFF, 8'hFF, 8'hAA, 8'h99, 8'h32, 8'h61, 8'h34, 8'h56, 8'h32,
            8'h81, 8'h0B, 8'h12, 8'h30, 8'hA1, 8'h00, 8'h0E, 8'h20, 8'h00};

    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {c0, s0, w0, b0, dn0, e0, d0}, 64'd0);
    reset = 1'b0;
    repeat (2) begin @(negedge clk); #1; end

    // Directed run, ack on the 3rd strobe cycle
    ack_lat = 3;
    run(24'h123456, 0, 0, res);
    check("t1_result", 64'(res), 64'd1);
    check("t1_nwrites", 64'(wq0.size()), 64'd18);
    if (wq0.size() == 18)
      for (int i = 0; i < 18; i++) check($sformatf("t1_byte%0d", i), {56'd0, wq0[i]}, {56'd0, lit[i]});
    if (wq1.size() == 18) begin
      check("swap_byte2", {56'd0, wq1[2]}, 64'h55);
      check("swap_byte3", {56'd0, wq1[3]}, 64'h99);
      check("swap_byte4", {56'd0, wq1[4]}, 64'h4C);
    end
    check("t1_span", 64'(done_cyc - first_stb + 1), 64'd72);
    check("t1_gaps", 64'(gap_n), 64'd17);
    check("t1_stb_cycles", 64'(stb_hi), 64'd54);
    check("t1_done_count", 64'(done_cnt), 64'd1);
    check("t1_err", {63'd0, e0}, 64'd0);

    // Slave never acks
    ack_lat = 0;
    run(24'hABCDEF, 0, 0, res);
    check("to_result", 64'(res), 64'd2);
    check("to_req_cycles", 64'(stb_hi), 64'd16);
    check("to_err_cyc", {62'd0, e0, c0}, 64'd2);
    check("to_no_done", 64'(done_cnt), 64'd0);
    ack_lat = 3;
    run(24'h00ABCD, 0, 0, res);
    check("to_restart_result", 64'(res), 64'd1);
    check_stream("to_restart_stream", 24'h00ABCD);

    // Ack on the very cycle the timeout would expire
    ack_lat = TO;
    run(24'h5A5A5A, 0, 0, res);
    check("edge_result", 64'(res), 64'd1);
    check("edge_err", {63'd0, e0}, 64'd0);
    check("edge_stb_cycles", 64'(stb_hi), 64'(18 * TO));

    // Repeated go and boot_addr change mid-run
    ack_lat = 3;
    run(24'h123456, 1, 5, res);
    check("rego_result", 64'(res), 64'd1);
    check_stream("rego_stream", 24'h123456);
    check("rego_done_count", 64'(done_cnt), 64'd1);

    // Reset at byte 9, then a fresh run
    run(24'h123456, 2, 9, res);
    check("rst_result", 64'(res), 64'd3);
    check("rst_no_done", 64'(done_cnt), 64'd0);
    run(24'h123456, 0, 0, res);
    check("rst_rerun_first", (wq0.size() > 0) ? {56'd0, wq0[0]} : 64'hDEAD, 64'hFF);
    check_stream("rst_rerun_stream", 24'h123456);

    // Randomized runs: random addresses, ack latencies, stray acks, extra go pulses
    rand_lat = 1'b1;
    spurious = 1'b1;
    for (int r = 0; r < 20; r++) begin
      logic [23:0] a;
      int kind;
      a = 24'($urandom);
      kind = ($urandom_range(0, 2) == 0) ? 1 : 0;
      run(a, kind, $urandom_range(1, 16), res);
      check("rand_result", 64'(res), 64'd1);
      check_stream("rand_stream", a);
      check("rand_done_count", 64'(done_cnt), 64'd1);
    end
    rand_lat = 1'b0;
    spurious = 1'b0;
    ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
